// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holding-buffer entries use these widths, so the top-level defaults track them.
package regfile_ctrl_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry write-back holding buffer: accepts a request whenever it is empty
// or being drained this cycle, so a granted requester can stream one per clock.
module wb_hold_buffer
  import regfile_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_ready,
  output wb_entry_t         o_entry
);

  wb_entry_t r_entry;

  assign o_ready = !r_entry.valid || i_grant;
  assign o_entry = r_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
    end else if (i_valid && o_ready) begin
      r_entry.valid <= 1'b1;
      r_entry.rd    <= i_rd;
      r_entry.data  <= i_data;
    end else if (i_grant) begin
      r_entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter between ALU and memory unit for the integer
// register file, plus a per-register pending-write scoreboard for decode.
module regfile_wb_arbiter #(
  parameter int DATA_W   = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W   = regfile_ctrl_pkg::ADDR_W,
  parameter int NREG     = 32,
  parameter int PEND_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData
);

  import regfile_ctrl_pkg::*;

  localparam int CNT_W = $clog2(PEND_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PEND_MAX);

  wb_entry_t         w_buf_a;
  wb_entry_t         w_buf_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_contend;
  logic              w_sel_valid;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_iss_fire;
  logic [CNT_W-1:0]  w_cnt [NREG];
  logic [CNT_W-1:0]  w_wr_cnt;

  logic              r_rr;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;

  wb_hold_buffer u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .i_valid (a_valid),
    .i_rd    (a_rd),
    .i_data  (a_data),
    .i_grant (w_grant_a),
    .o_ready (a_ready),
    .o_entry (w_buf_a)
  );

  wb_hold_buffer u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .i_valid (b_valid),
    .i_rd    (b_rd),
    .i_data  (b_data),
    .i_grant (w_grant_b),
    .o_ready (b_ready),
    .o_entry (w_buf_b)
  );

  // Grants depend only on buffered state, keeping ready free of valid/data paths.
  assign w_contend   = w_buf_a.valid && w_buf_b.valid;
  assign w_grant_a   = w_buf_a.valid && (!w_buf_b.valid || r_rr == REQ_ALU);
  assign w_grant_b   = w_buf_b.valid && (!w_buf_a.valid || r_rr == REQ_MEM);
  assign w_sel_valid = w_grant_a || w_grant_b;
  assign w_sel_rd    = w_grant_b ? w_buf_b.rd : w_buf_a.rd;
  assign w_sel_data  = w_grant_b ? w_buf_b.data : w_buf_a.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= REQ_ALU;
    end else if (w_contend) begin
      r_rr <= w_grant_a ? REQ_MEM : REQ_ALU;
    end
  end

  // x0 entries drain through the grant but never touch the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_sel_valid && (w_sel_rd != '0);
      if (w_sel_valid && (w_sel_rd != '0)) begin
        r_write_reg  <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
    end
  end

  assign regWrite      = r_reg_write;
  assign writeRegister = r_write_reg;
  assign writeData     = r_write_data;

  assign w_iss_fire = iss_valid && iss_ready && (iss_rd != '0);
  assign w_cnt[0]   = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;

      assign w_inc = w_iss_fire && (iss_rd == ADDR_W'(gi));
      assign w_dec = r_reg_write && (r_write_reg == ADDR_W'(gi)) && (r_cnt != '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign iss_ready = (iss_rd == '0) || (w_cnt[iss_rd] != CNT_MAX);
  assign rs1_busy  = (w_cnt[rs1] != '0);
  assign rs2_busy  = (w_cnt[rs2] != '0);

  // A retire with no outstanding issue means decode and write-back disagree.
  assign w_wr_cnt = w_cnt[r_write_reg];

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    r_reg_write |-> (w_wr_cnt != '0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table, hand-written corner sequences and a randomized run
// against a cycle-level behavioural model of the write-back arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [63:0] b_data;
  logic        b_ready;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [63:0] writeData;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rw, input logic [4:0] e_wr,
                            input logic [63:0] e_wd, input logic e_ar, input logic e_br,
                            input logic e_ir, input logic e_b1, input logic e_b2);
    chk({tag, "_regWrite"}, 64'(regWrite), 64'(e_rw));
    chk({tag, "_writeRegister"}, 64'(writeRegister), 64'(e_wr));
    chk({tag, "_writeData"}, writeData, e_wd);
    chk({tag, "_a_ready"}, 64'(a_ready), 64'(e_ar));
    chk({tag, "_b_ready"}, 64'(b_ready), 64'(e_br));
    chk({tag, "_iss_ready"}, 64'(iss_ready), 64'(e_ir));
    chk({tag, "_rs1_busy"}, 64'(rs1_busy), 64'(e_b1));
    chk({tag, "_rs2_busy"}, 64'(rs2_busy), 64'(e_b2));
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic iv; logic [4:0] ird;
    logic av; logic [4:0] ard; logic [63:0] ad;
    logic bv; logic [4:0] brd; logic [63:0] bd;
    logic [4:0] r1; logic [4:0] r2;
    logic e_rw; logic [4:0] e_wr; logic [63:0] e_wd;
    logic e_ar; logic e_br; logic e_ir; logic e_b1; logic e_b2;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  // ---------------- behavioural model ----------------
  logic        mv [2];
  logic [4:0]  mrd [2];
  logic [63:0] md [2];
  int          m_last_winner;   // 0 = ALU, 1 = MEM; the next contention goes to the other
  int          m_cnt [32];
  int          owed [32];       // issued but not yet handed to a requester
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [63:0] m_wd;
  logic        mg [2];
  logic        mready [2];
  logic        m_ir, m_b1, m_b2;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin mv[i] = 0; mrd[i] = 0; md[i] = 0; end
    for (int r = 0; r < 32; r++) begin m_cnt[r] = 0; owed[r] = 0; end
    m_last_winner = 1;
    m_rw = 0; m_wr = 0; m_wd = 0;
  endtask

  task automatic m_comb();
    if (mv[0] && mv[1]) begin
      mg[0] = (m_last_winner == 1);
      mg[1] = (m_last_winner == 0);
    end else begin
      mg[0] = mv[0];
      mg[1] = mv[1];
    end
    for (int i = 0; i < 2; i++) mready[i] = !mv[i] || mg[i];
    m_ir = (iss_rd == 0) || (m_cnt[iss_rd] < 3);
    m_b1 = m_cnt[rs1] > 0;
    m_b2 = m_cnt[rs2] > 0;
  endtask

  task automatic m_step();
    int w;
    logic acc [2];
    acc[0] = a_valid && mready[0];
    acc[1] = b_valid && mready[1];
    if (m_rw && m_cnt[m_wr] > 0) m_cnt[m_wr]--;
    if (iss_valid && m_ir && iss_rd != 0) m_cnt[iss_rd]++;
    w = mg[0] ? 0 : (mg[1] ? 1 : -1);
    if (w >= 0 && mrd[w] != 0) begin
      m_rw = 1; m_wr = mrd[w]; m_wd = md[w];
    end else begin
      m_rw = 0;
    end
    if (mv[0] && mv[1]) m_last_winner = w;
    for (int i = 0; i < 2; i++) if (mg[i]) mv[i] = 0;
    if (acc[0]) begin mv[0] = 1; mrd[0] = a_rd; md[0] = a_data; end
    if (acc[1]) begin mv[1] = 1; mrd[1] = b_rd; md[1] = b_data; end
  endtask

  function automatic int pick_rd();
    int start;
    start = $urandom_range(0, 6);
    for (int k = 0; k < 7; k++) begin
      int r;
      r = 1 + (start + k) % 7;
      if (owed[r] > 0) return r;
    end
    return -1;
  endfunction

  initial begin
    int ai, bi, wi;
    logic [4:0] exp_order [8];
    logic [4:0] ord_a [8];
    logic [4:0] ord_b [8];

    vecs[0]  = '{1,7, 0,0,64'h0,    0,0,64'h0,    7,3, 0,0,64'h0,    1,1,1,0,0};
    vecs[1]  = '{0,0, 1,7,64'hDEAD, 0,0,64'h0,    7,3, 0,0,64'h0,    1,1,1,1,0};
    vecs[2]  = '{0,0, 0,0,64'h0,    0,0,64'h0,    7,3, 0,0,64'h0,    1,1,1,1,0};
    vecs[3]  = '{0,0, 0,0,64'h0,    0,0,64'h0,    7,3, 1,7,64'hDEAD, 1,1,1,1,0};
    vecs[4]  = '{0,0, 0,0,64'h0,    0,0,64'h0,    7,3, 0,7,64'hDEAD, 1,1,1,0,0};
    vecs[5]  = '{0,0, 0,0,64'h0,    1,0,64'hFFFF, 0,0, 0,7,64'hDEAD, 1,1,1,0,0};
    vecs[6]  = '{0,0, 0,0,64'h0,    0,0,64'h0,    0,0, 0,7,64'hDEAD, 1,1,1,0,0};
    vecs[7]  = '{0,0, 0,0,64'h0,    0,0,64'h0,    0,0, 0,7,64'hDEAD, 1,1,1,0,0};
    vecs[8]  = '{1,9, 0,0,64'h0,    0,0,64'h0,    9,0, 0,7,64'hDEAD, 1,1,1,0,0};
    vecs[9]  = '{1,9, 0,0,64'h0,    0,0,64'h0,    9,0, 0,7,64'hDEAD, 1,1,1,1,0};
    vecs[10] = '{1,9, 0,0,64'h0,    0,0,64'h0,    9,0, 0,7,64'hDEAD, 1,1,1,1,0};
    vecs[11] = '{1,9, 0,0,64'h0,    0,0,64'h0,    9,0, 0,7,64'hDEAD, 1,1,0,1,0};
    vecs[12] = '{0,10,1,9,64'h99,   0,0,64'h0,    9,0, 0,7,64'hDEAD, 1,1,1,1,0};
    vecs[13] = '{0,9, 0,0,64'h0,    0,0,64'h0,    9,0, 0,7,64'hDEAD, 1,1,0,1,0};
    vecs[14] = '{0,9, 0,0,64'h0,    0,0,64'h0,    9,0, 1,9,64'h99,   1,1,0,1,0};
    vecs[15] = '{0,9, 0,0,64'h0,    0,0,64'h0,    9,0, 0,9,64'h99,   1,1,1,1,0};
    vecs[16] = '{1,3, 0,0,64'h0,    0,0,64'h0,    0,3, 0,9,64'h99,   1,1,1,0,0};
    vecs[17] = '{0,0, 1,3,64'h33,   0,0,64'h0,    0,3, 0,9,64'h99,   1,1,1,0,1};
    vecs[18] = '{0,0, 0,0,64'h0,    0,0,64'h0,    0,3, 0,9,64'h99,   1,1,1,0,1};
    vecs[19] = '{1,3, 0,0,64'h0,    0,0,64'h0,    0,3, 1,3,64'h33,   1,1,1,0,1};
    vecs[20] = '{0,3, 0,0,64'h0,    0,0,64'h0,    0,3, 0,3,64'h33,   1,1,1,0,1};

    // Reset values, held through two edges.
    idle_inputs();
    rs1 = 5'd5; rs2 = 5'd7;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_outs("reset", 0, 0, 64'h0, 1, 1, 1, 0, 0);
    $display("reset values checked");
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
      a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_data = vecs[i].bd;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].e_rw, vecs[i].e_wr, vecs[i].e_wd,
                 vecs[i].e_ar, vecs[i].e_br, vecs[i].e_ir, vecs[i].e_b1, vecs[i].e_b2);
      $display("row %0d regWrite=%0b writeRegister=%0d writeData=%0h iss_ready=%0b",
               i, regWrite, writeRegister, writeData, iss_ready);
    end

    // Contention: both requesters streaming; writes must alternate A,B,A,B...
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      iss_valid = 1'b1;
      iss_rd = (k < 4) ? 5'(1 + k) : 5'(11 + k - 4);
      @(negedge clk);
    end
    iss_valid = 1'b0; iss_rd = '0;
    for (int k = 0; k < 4; k++) begin
      ord_a[k] = 5'(1 + k); ord_b[k] = 5'(11 + k);
      exp_order[2*k] = ord_a[k]; exp_order[2*k+1] = ord_b[k];
    end
    ai = 0; bi = 0; wi = 0;
    for (int cyc = 0; cyc < 40 && wi < 8; cyc++) begin
      a_valid = (ai < 4); a_rd = (ai < 4) ? ord_a[ai] : 5'd0; a_data = 64'(100 + ai);
      b_valid = (bi < 4); b_rd = (bi < 4) ? ord_b[bi] : 5'd0; b_data = 64'(200 + bi);
      #1;
      if (regWrite) begin
        chk($sformatf("contend_order%0d", wi), 64'(writeRegister), 64'(exp_order[wi]));
        $display("contention write %0d writeRegister=%0d", wi, writeRegister);
        wi++;
      end
      if (a_valid && a_ready) ai++;
      if (b_valid && b_ready) bi++;
      @(negedge clk);
    end
    chk("contend_write_count", 64'(wi), 64'd8);
    idle_inputs();

    // Reset mid-stream with both buffers full and two writes pending on r5.
    pulse_reset();
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk); @(negedge clk);
    iss_valid = 1'b0; iss_rd = '0;
    a_valid = 1'b1; a_rd = '0; a_data = 64'h1;
    b_valid = 1'b1; b_rd = '0; b_data = 64'h2;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd5;
    #1;
    chk("pre_rst_rs1_busy", 64'(rs1_busy), 64'd1);
    chk("pre_rst_ready_both", 64'(a_ready & b_ready), 64'd0);
    rst = 1'b1;
    #1;
    check_outs("midrst", 0, 0, 64'h0, 1, 1, 1, 0, 0);
    @(negedge clk);
    check_outs("midrst_held", 0, 0, 64'h0, 1, 1, 1, 0, 0);
    $display("mid-stream reset checked");
    rst = 1'b0;
    idle_inputs();

    // Randomized run against the behavioural model.
    m_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic do_rst;
      int r;
      @(negedge clk);
      do_rst = ($urandom_range(0, 79) == 0);
      rst = do_rst;
      if (do_rst) m_reset();
      iss_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      m_comb();
      a_valid = 1'b0; b_valid = 1'b0;
      if (!do_rst && $urandom_range(0, 3) != 0) begin
        r = ($urandom_range(0, 7) == 0) ? 0 : pick_rd();
        if (r >= 0) begin
          a_valid = 1'b1; a_rd = 5'(r); a_data = {$urandom, $urandom};
          if (mready[0] && r != 0) owed[r]--;
        end
      end
      if (!do_rst && $urandom_range(0, 3) != 0) begin
        r = ($urandom_range(0, 7) == 0) ? 0 : pick_rd();
        if (r >= 0) begin
          b_valid = 1'b1; b_rd = 5'(r); b_data = {$urandom, $urandom};
          if (mready[1] && r != 0) owed[r]--;
        end
      end
      iss_valid = !do_rst && ($urandom_range(0, 1) == 1);
      if (iss_valid && m_ir && iss_rd != 0) owed[iss_rd]++;
      #1;
      check_outs($sformatf("rand%0d", cyc), m_rw, m_wr, m_wd,
                 mready[0], mready[1], m_ir, m_b1, m_b2);
      @(posedge clk);
      if (!do_rst) m_step();
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the integer `register_file`. It shares the single register-file write port between two write-back requesters, the ALU and the memory unit, using round-robin arbitration. Each requester sees a valid/ready handshake backed by a one-entry holding buffer. A per-register pending-write counter gives decode the busy status of its source registers and throttles issue.

## Interface
Parameters:
- `DATA_W`, 64: write-data width.
- `ADDR_W`, 5: register index width.
- `NREG`, 32: number of architectural registers.
- `PEND_MAX`, 3: maximum outstanding writes per register.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `iss_valid`  in  1  decode issues an instruction that writes `iss_rd`.
- `iss_rd`  in  ADDR_W  destination of the issuing instruction.
- `iss_ready`  out  1  issue accepted; low when `iss_rd` counter = PEND_MAX.
- `rs1`, `rs2`  in  ADDR_W  source registers being checked by decode.
- `rs1_busy`, `rs2_busy`  out  1  source has outstanding writes (combinational).
- `a_valid`, `a_rd`, `a_data`  in  1/ADDR_W/DATA_W  ALU write-back request.
- `a_ready`  out  1  ALU request accepted this cycle.
- `b_valid`, `b_rd`, `b_data`  in  1/ADDR_W/DATA_W  memory-unit write-back request.
- `b_ready`  out  1  memory-unit request accepted this cycle.
- `regWrite`  out  1  write enable to `register_file`; registered.
- `writeRegister`  out  ADDR_W  write index; registered.
- `writeData`  out  DATA_W  write data; registered.

## Operation
- **Holding buffers:** one buffer per requester (`{valid, rd, data}`).
  - `x_ready = !buf_x.valid || grant_x` (combinational).
  - A request is accepted on the rising edge when `x_valid && x_ready`.
- **Arbitration:** combinational over the buffer valid bits.
  - Exactly one buffer valid: grant it.
  - Both valid: grant the requester named by round-robin pointer `rr`.
  - `rr` is updated only on contention, to point at the loser. On reset `rr` = A.
- **Write port:** the granted entry loads the output registers at the next edge.
  - `regWrite` = 1 iff a grant occurred and `rd != 0`.
  - Otherwise `regWrite` = 0. `writeRegister` and `writeData` hold their last values.
- **x0:** requests with `rd = 0` are accepted, granted and drained normally but never assert `regWrite`.
- **Scoreboard:** `cnt[r]`, width `$clog2(PEND_MAX+1)`, for r = 1..NREG-1. `cnt[0]` is constant 0.
  - Increment on `iss_valid && iss_ready && iss_rd != 0`.
  - Decrement for `writeRegister` on each edge where `regWrite` = 1.
  - Increment and decrement to the same register on the same edge: count unchanged.
  - `iss_ready = (iss_rd == 0) || cnt[iss_rd] != PEND_MAX`.
  - `rsN_busy = cnt[rsN] != 0`. This is always 0 for `rsN = 0`.
- **Error guard:** a decrement at count 0 is ignored (simulation assertion fires).
- **Reset:** asserting `rst` at any time clears all buffers, counters, `rr` and the write registers. In-flight writes are discarded.

## Timing
- **Reset values:**
  - `regWrite` = 0, `writeRegister` = 0, `writeData` = 0.
  - `a_ready` = `b_ready` = 1 and `iss_ready` = 1.
  - `rs1_busy` = `rs2_busy` = 0.
- **Write-back latency:** request accepted at edge N → buffered → granted → `regWrite` high during cycle N+1..N+2 → `register_file` commits on the falling edge inside that cycle → counter decremented at edge N+2.
- **Busy clearing:** `rsN_busy` drops after edge N+2. A read issued then sees the new value.
- **Throughput:** one uncontended requester sustains one write per cycle, since the buffer drains and refills on the same edge.
- **Contention:** with both requesters streaming, grants strictly alternate and each sees `ready` on every other cycle.
- **Combinational outputs:** `x_ready`, `iss_ready` and `rsN_busy` have no combinational path from `x_valid` or `x_data`.

## Structure
- Package `regfile_ctrl_pkg` contains:
  - `DATA_W` and `ADDR_W` defaults.
  - Requester encoding `REQ_ALU = 1'b0`, `REQ_MEM = 1'b1`.
  - Typedef `wb_entry_t {logic valid; logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;}`.
- Sub-module `wb_hold_buffer`: one-entry buffer with valid/ready, instantiated once per requester. Arbiter, write-port registers and scoreboard stay in the top level.

## Test plan
- Reset mid-stream: drive `rst` high with both buffers full and `cnt[5]` = 2 → next cycle `regWrite` = 0, `rs1_busy(rs1=5)` = 0, both `ready` = 1.
- Single ALU write: issue rd=7, then `a_valid` rd=7 data=0xDEAD at edge N → `regWrite`=1, `writeRegister`=7, `writeData`=0xDEAD in cycle N+1; `rs1_busy(7)` is 1 until edge N+2, then 0.
- Contention: both valid continuously, A rd=1..4, B rd=11..14 → write order 1,11,2,12,3,13,4,14; `rr` alternates.
- x0 drop: `b_valid` rd=0 data=0xFFFF → `b_ready`=1, `regWrite` stays 0, no counter changes.
- Scoreboard saturation: issue rd=9 three times with no write-back → `iss_ready`=0 for rd=9 and 1 for rd=10. One write to rd=9 → `iss_ready` for rd=9 returns to 1 after that edge.
- Simultaneous issue and retire on rd=3 with `cnt[3]`=1 → `cnt[3]` stays 1 and `rs2_busy(3)` stays 1.
